// File: rtl/lumi_linkseq.sv
`default_nettype none
// ============================================================================
// Module   : lumi_linkseq
// Summary  : LUMI link bring-up sequencer. Once the PHY link is up it programs
//            and checks the LUMI control registers over a UMI host port.
// Revision : 1.0 - initial release
// ============================================================================
module lumi_linkseq #(
  parameter int            CW         = 32,
  parameter int            AW         = 64,
  parameter int            RW         = 32,
  parameter logic [AW-1:0] REGBASE    = '0,
  parameter logic [AW-1:0] SRCADDR    = '0,
  parameter logic [15:0]   CRDTINTRVL = 16'h00FF,
  parameter int            TOW        = 16,
  parameter int            TIMEOUT    = 1023
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          i_en,
  input  logic          i_phy_linkactive,
  input  logic [7:0]    i_phy_iow,
  output logic          o_uhost_req_valid,
  output logic [CW-1:0] o_uhost_req_cmd,
  output logic [AW-1:0] o_uhost_req_dstaddr,
  output logic [AW-1:0] o_uhost_req_srcaddr,
  output logic [RW-1:0] o_uhost_req_data,
  input  logic          i_uhost_req_ready,
  input  logic          i_uhost_resp_valid,
  input  logic [CW-1:0] i_uhost_resp_cmd,
  input  logic [AW-1:0] i_uhost_resp_dstaddr,
  input  logic [AW-1:0] i_uhost_resp_srcaddr,
  input  logic [RW-1:0] i_uhost_resp_data,
  output logic          o_uhost_resp_ready,
  output logic          o_seq_busy,
  output logic          o_seq_done,
  output logic          o_seq_error,
  output logic [2:0]    o_seq_errcode
);

  // LUMI register map offsets
  localparam logic [7:0] c_OFS_STATUS     = 8'h04;
  localparam logic [7:0] c_OFS_TXMODE     = 8'h10;
  localparam logic [7:0] c_OFS_CRDTINTRVL = 8'h24;

  localparam logic [4:0] c_REQ_READ   = 5'h01;
  localparam logic [4:0] c_REQ_WRITE  = 5'h03;
  localparam logic [4:0] c_RESP_READ  = 5'h02;
  localparam logic [4:0] c_RESP_WRITE = 5'h04;

  localparam logic [2:0]     c_ERR_TIMEOUT = 3'd1;
  localparam logic [2:0]     c_ERR_RESP    = 3'd2;
  localparam logic [2:0]     c_ERR_TXMODE  = 3'd3;
  localparam logic [2:0]     c_ERR_STATUS  = 3'd4;
  localparam logic [TOW-1:0] c_TIMEOUT     = TOW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAITLINK = 3'd1,
    S_REQ      = 3'd2,
    S_RESP     = 3'd3,
    S_DONE     = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_step;
  logic [1:0]     w_step_nxt;
  logic           r_abort;
  logic           w_abort_nxt;
  logic [TOW-1:0] r_cnt;
  logic [TOW-1:0] w_cnt_inc;

  logic           r_req_valid;
  logic [CW-1:0]  r_req_cmd;
  logic [AW-1:0]  r_req_dstaddr;
  logic [AW-1:0]  r_req_srcaddr;
  logic [RW-1:0]  r_req_data;
  logic           r_resp_ready;
  logic           r_busy;
  logic           r_done;
  logic           r_error;
  logic [2:0]     r_errcode;

  logic [CW-1:0]  w_req_cmd;
  logic [AW-1:0]  w_req_dstaddr;
  logic [RW-1:0]  w_req_data;
  logic           w_req_hs;
  logic           w_resp_hs;
  logic           w_timeout;
  logic           w_link_lost;
  logic [4:0]     w_resp_op_exp;
  logic [2:0]     w_code;
  logic           w_unused;

  assign w_req_hs    = r_req_valid & i_uhost_req_ready;
  assign w_resp_hs   = r_resp_ready & i_uhost_resp_valid;
  assign w_cnt_inc   = (r_cnt >= c_TIMEOUT) ? c_TIMEOUT : r_cnt + TOW'(1);
  assign w_timeout   = (r_state == S_RESP) && !w_resp_hs && (w_cnt_inc == c_TIMEOUT);
  assign w_link_lost = r_abort | ~i_phy_linkactive;
  assign w_unused    = ^{i_uhost_resp_cmd, i_uhost_resp_srcaddr, i_uhost_resp_data};

  // Request image for the current step
  always_comb begin
    w_req_cmd      = '0;
    w_req_cmd[7:5] = 3'd2;
    w_req_dstaddr  = '0;
    w_req_data     = '0;
    case (r_step)
      2'd0: begin
        w_req_cmd[4:0] = c_REQ_WRITE;
        w_req_dstaddr  = REGBASE + AW'(c_OFS_CRDTINTRVL);
        w_req_data     = RW'(CRDTINTRVL);
      end
      2'd1: begin
        w_req_cmd[4:0] = c_REQ_READ;
        w_req_dstaddr  = REGBASE + AW'(c_OFS_TXMODE);
      end
      default: begin
        w_req_cmd[4:0] = c_REQ_READ;
        w_req_dstaddr  = REGBASE + AW'(c_OFS_STATUS);
      end
    endcase
  end

  // Outcome of the transaction in flight; only meaningful when it ends
  always_comb begin
    w_resp_op_exp = (r_step == 2'd0) ? c_RESP_WRITE : c_RESP_READ;
    w_code        = 3'd0;
    if (!w_resp_hs) begin
      w_code = c_ERR_TIMEOUT;
    end else if ((i_uhost_resp_cmd[4:0] != w_resp_op_exp) ||
                 (i_uhost_resp_dstaddr != SRCADDR)) begin
      w_code = c_ERR_RESP;
    end else if ((r_step == 2'd1) &&
                 ((i_uhost_resp_data[23:16] != i_phy_iow) || !i_uhost_resp_data[0])) begin
      w_code = c_ERR_TXMODE;
    end else if ((r_step == 2'd2) && !i_uhost_resp_data[4]) begin
      w_code = c_ERR_STATUS;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_abort_nxt = r_abort;
    case (r_state)
      S_IDLE: begin
        if (i_en) w_state_nxt = S_WAITLINK;
      end
      S_WAITLINK: begin
        if (!i_en) begin
          w_state_nxt = S_IDLE;
        end else if (i_phy_linkactive) begin
          w_step_nxt  = 2'd0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (!i_phy_linkactive) w_abort_nxt = 1'b1;
        if (w_req_hs) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (!i_phy_linkactive) w_abort_nxt = 1'b1;
        if (w_resp_hs || w_timeout) begin
          // A link loss during the transaction overrides any result it produced
          if (w_link_lost) begin
            w_abort_nxt = 1'b0;
            w_state_nxt = S_WAITLINK;
          end else if (!i_en) begin
            w_state_nxt = S_IDLE;
          end else if (w_code != 3'd0) begin
            w_state_nxt = S_ERROR;
          end else if (r_step == 2'd2) begin
            w_state_nxt = S_DONE;
          end else begin
            w_step_nxt  = r_step + 2'd1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (!i_phy_linkactive) w_state_nxt = S_WAITLINK;
        else if (!i_en)        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state       <= S_IDLE;
      r_step        <= 2'd0;
      r_abort       <= 1'b0;
      r_cnt         <= '0;
      r_req_valid   <= 1'b0;
      r_req_cmd     <= '0;
      r_req_dstaddr <= '0;
      r_req_srcaddr <= '0;
      r_req_data    <= '0;
      r_resp_ready  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_errcode     <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_step       <= w_step_nxt;
      r_abort      <= w_abort_nxt;
      r_req_valid  <= (r_state == S_REQ) && !w_req_hs;
      r_resp_ready <= (w_state_nxt == S_RESP);
      r_busy       <= (w_state_nxt == S_REQ) || (w_state_nxt == S_RESP);
      r_done       <= (w_state_nxt == S_DONE);
      r_error      <= (w_state_nxt == S_ERROR);
      if (w_req_hs) begin
        r_cnt <= '0;
      end else if (r_state == S_RESP) begin
        r_cnt <= w_cnt_inc;
      end
      // Fields are loaded together with valid and then held until accepted
      if ((r_state == S_REQ) && !r_req_valid) begin
        r_req_cmd     <= w_req_cmd;
        r_req_dstaddr <= w_req_dstaddr;
        r_req_srcaddr <= SRCADDR;
        r_req_data    <= w_req_data;
      end
      if (w_state_nxt != S_ERROR) begin
        r_errcode <= 3'd0;
      end else if (r_state != S_ERROR) begin
        r_errcode <= w_code;
      end
    end
  end

  assign o_uhost_req_valid   = r_req_valid;
  assign o_uhost_req_cmd     = r_req_cmd;
  assign o_uhost_req_dstaddr = r_req_dstaddr;
  assign o_uhost_req_srcaddr = r_req_srcaddr;
  assign o_uhost_req_data    = r_req_data;
  assign o_uhost_resp_ready  = r_resp_ready;
  assign o_seq_busy          = r_busy;
  assign o_seq_done          = r_done;
  assign o_seq_error         = r_error;
  assign o_seq_errcode       = r_errcode;

endmodule
`default_nettype wire
